// File: rtl/fire_request_sequencer.sv
// Debounces the fire/refill buttons and sequences trigger/refill requests to the web shooter.
// Define SEQ_SHOT_COUNT_EN to implement the saturating shot_count register; otherwise shot_count is 0.
module fire_request_sequencer #(
    parameter int unsigned DEBOUNCE     = 4,
    parameter int unsigned RESP_TIMEOUT = 8,
    parameter int unsigned GAP          = 3,
    parameter int unsigned REFILL_HOLD  = 4,
    parameter int unsigned BURST_LEN    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_fire,
    input  logic       btn_refill,
    input  logic [2:0] mode_in,
    input  logic [4:0] targets_in,
    input  logic       shoot,
    output logic       trigger,
    output logic       refill,
    output logic [2:0] fire_mode,
    output logic [4:0] target_cnt,
    output logic       busy,
    output logic       shot_ok,
    output logic       shot_fail,
    output logic [7:0] shot_count
);

    localparam int unsigned DB_W    = $clog2(DEBOUNCE + 1);
    localparam int unsigned TMR_MAX = (RESP_TIMEOUT > GAP)
                                    ? ((RESP_TIMEOUT > REFILL_HOLD) ? RESP_TIMEOUT : REFILL_HOLD)
                                    : ((GAP > REFILL_HOLD) ? GAP : REFILL_HOLD);
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned BURST_W = 4;
    localparam logic [2:0]  MODE_RAPID = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_TRIG,
        S_RELEASE,
        S_REFILL,
        S_REFILL_GAP
    } state_t;

    // bit 0 = fire, bit 1 = refill
    logic [1:0]      raw;
    logic [1:0]      deb_lvl;
    logic [1:0]      deb_lvl_q;
    logic [1:0]      btn_armed;
    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      btn_edge_c;

    state_t               state;
    state_t               state_nxt;
    logic [TMR_W-1:0]     tmr;
    logic [TMR_W-1:0]     tmr_nxt;
    logic [BURST_W-1:0]   burst;
    logic [BURST_W-1:0]   burst_nxt;
    logic                 latch_c;
    logic                 ok_c;
    logic                 fail_c;

    assign raw = {btn_refill, btn_fire};

    // Debounce; a button only arms after it has been seen released, so a press held through reset never fires.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_lvl   <= '0;
            deb_lvl_q <= '0;
            btn_armed <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            deb_lvl_q <= deb_lvl;
            for (int i = 0; i < 2; i++) begin
                if (!raw[i] && !deb_lvl[i]) begin
                    btn_armed[i] <= 1'b1;
                end
                if (raw[i] == deb_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
                    deb_lvl[i] <= ~deb_lvl[i];
                    db_cnt[i]  <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign btn_edge_c = deb_lvl & ~deb_lvl_q & btn_armed;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, timer and burst bookkeeping
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        burst_nxt = burst;
        latch_c   = 1'b0;
        ok_c      = 1'b0;
        fail_c    = 1'b0;
        case (state)
            S_IDLE: begin
                tmr_nxt = '0;
                if (btn_edge_c[0]) begin
                    state_nxt = S_ARM;
                    latch_c   = 1'b1;
                    burst_nxt = (mode_in == MODE_RAPID) ? BURST_W'(BURST_LEN) : BURST_W'(1);
                end else if (btn_edge_c[1]) begin
                    state_nxt = S_REFILL;
                end
            end
            S_ARM: begin
                tmr_nxt   = '0;
                state_nxt = S_TRIG;
            end
            S_TRIG: begin
                if (shoot) begin
                    ok_c      = 1'b1;
                    burst_nxt = burst - BURST_W'(1);
                    tmr_nxt   = '0;
                    state_nxt = S_RELEASE;
                end else if (tmr == TMR_W'(RESP_TIMEOUT - 1)) begin
                    fail_c    = 1'b1;
                    burst_nxt = '0;
                    tmr_nxt   = '0;
                    state_nxt = S_RELEASE;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            S_RELEASE: begin
                if (tmr == TMR_W'(GAP - 1)) begin
                    tmr_nxt   = '0;
                    state_nxt = (burst != '0) ? S_ARM : S_IDLE;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            S_REFILL: begin
                if (tmr == TMR_W'(REFILL_HOLD - 1)) begin
                    tmr_nxt   = '0;
                    state_nxt = S_REFILL_GAP;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            S_REFILL_GAP: begin
                if (tmr == TMR_W'(GAP - 1)) begin
                    tmr_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                tmr_nxt   = '0;
                burst_nxt = '0;
            end
        endcase
    end

    // Registered outputs follow the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmr        <= '0;
            burst      <= '0;
            trigger    <= 1'b0;
            refill     <= 1'b0;
            busy       <= 1'b0;
            shot_ok    <= 1'b0;
            shot_fail  <= 1'b0;
            fire_mode  <= '0;
            target_cnt <= '0;
        end else begin
            tmr       <= tmr_nxt;
            burst     <= burst_nxt;
            trigger   <= (state_nxt == S_TRIG);
            refill    <= (state_nxt == S_REFILL);
            busy      <= (state_nxt != S_IDLE);
            shot_ok   <= ok_c;
            shot_fail <= fail_c;
            if (latch_c) begin
                fire_mode  <= mode_in;
                target_cnt <= targets_in;
            end
        end
    end

`ifdef SEQ_SHOT_COUNT_EN
    logic [7:0] shot_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            shot_cnt_q <= '0;
        end else if (ok_c && (shot_cnt_q != 8'hFF)) begin
            shot_cnt_q <= shot_cnt_q + 8'd1;
        end
    end

    assign shot_count = shot_cnt_q;
`else
    assign shot_count = 8'd0;
`endif

endmodule

// File: tb/tb_fire_request_sequencer.sv
// Directed self-checking bench for fire_request_sequencer (default or SEQ_SHOT_COUNT_EN build).
module tb_fire_request_sequencer;

`ifdef SEQ_SHOT_COUNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_fire = 1'b0;
    logic       btn_refill = 1'b0;
    logic [2:0] mode_in = 3'd0;
    logic [4:0] targets_in = 5'd0;
    logic       shoot = 1'b0;
    logic       trigger;
    logic       refill;
    logic [2:0] fire_mode;
    logic [4:0] target_cnt;
    logic       busy;
    logic       shot_ok;
    logic       shot_fail;
    logic [7:0] shot_count;

    fire_request_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .btn_fire   (btn_fire),
        .btn_refill (btn_refill),
        .mode_in    (mode_in),
        .targets_in (targets_in),
        .shoot      (shoot),
        .trigger    (trigger),
        .refill     (refill),
        .fire_mode  (fire_mode),
        .target_cnt (target_cnt),
        .busy       (busy),
        .shot_ok    (shot_ok),
        .shot_fail  (shot_fail),
        .shot_count (shot_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Running event counters, sampled mid-cycle
    int   n_trig_cyc = 0;
    int   n_rise = 0;
    int   n_ok = 0;
    int   n_fail = 0;
    int   n_refill_cyc = 0;
    int   n_overlap = 0;
    int   n_both_pulse = 0;
    int   n_short_gap = 0;
    int   low_run = 0;
    logic trig_prev = 1'b0;
    logic seen_trig = 1'b0;

    always @(negedge clk) begin
        if (trigger) n_trig_cyc++;
        if (refill) n_refill_cyc++;
        if (shot_ok) n_ok++;
        if (shot_fail) n_fail++;
        if (trigger && refill) n_overlap++;
        if (shot_ok && shot_fail) n_both_pulse++;
        if (trigger && !trig_prev) begin
            n_rise++;
            if (seen_trig && low_run < 4) n_short_gap++;
            seen_trig = 1'b1;
        end
        if (trigger) low_run = 0;
        else low_run++;
        trig_prev = trigger;
    end

    int b_trig_cyc, b_rise, b_ok, b_fail, b_refill_cyc;

    task automatic snap();
        b_trig_cyc   = n_trig_cyc;
        b_rise       = n_rise;
        b_ok         = n_ok;
        b_fail       = n_fail;
        b_refill_cyc = n_refill_cyc;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        step(2);
        chk("rst_trigger", 32'(trigger), 32'd0);
        chk("rst_refill", 32'(refill), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ok_fail", 32'({shot_ok, shot_fail}), 32'd0);
        chk("rst_mode_tgt", 32'({fire_mode, target_cnt}), 32'd0);
        chk("rst_count", 32'(shot_count), 32'd0);
        reset = 1'b0;
        step(3);

        // Three-cycle glitch must not fire
        snap();
        btn_fire = 1'b1;
        step(3);
        btn_fire = 1'b0;
        step(10);
        chk("glitch_no_trig", 32'(n_rise - b_rise), 32'd0);
        chk("glitch_idle", 32'(busy), 32'd0);

        // Single shot, mode 000 targets 1, shoot on 3rd TRIG cycle
        snap();
        mode_in    = 3'b000;
        targets_in = 5'd1;
        btn_fire   = 1'b1;
        step(4);
        chk("ss_edge_trig", 32'(trigger), 32'd0);
        chk("ss_edge_busy", 32'(busy), 32'd0);
        step(1);
        chk("ss_arm_busy", 32'(busy), 32'd1);
        chk("ss_arm_trig", 32'(trigger), 32'd0);
        chk("ss_arm_mode", 32'(fire_mode), 32'd0);
        chk("ss_arm_tgt", 32'(target_cnt), 32'd1);
        step(1);
        chk("ss_trig_latency", 32'(trigger), 32'd1);
        step(2);
        shoot = 1'b1;
        step(1);
        shoot = 1'b0;
        chk("ss_rel_trig", 32'(trigger), 32'd0);
        chk("ss_ok_pulse", 32'(shot_ok), 32'd1);
        chk("ss_count", 32'(shot_count), 32'(CNT_EN * 1));
        step(1);
        chk("ss_ok_one_cycle", 32'(shot_ok), 32'd0);
        step(1);
        chk("ss_rel3_busy", 32'(busy), 32'd1);
        step(1);
        chk("ss_idle_busy", 32'(busy), 32'd0);
        chk("ss_trig_cycles", 32'(n_trig_cyc - b_trig_cyc), 32'd3);
        step(6);
        btn_fire = 1'b0;
        step(8);
        chk("ss_hold_no_repeat", 32'(n_rise - b_rise), 32'd1);
        chk("ss_ok_total", 32'(n_ok - b_ok), 32'd1);

        // Timeout: shoot never answers
        snap();
        mode_in    = 3'b011;
        targets_in = 5'd5;
        btn_fire   = 1'b1;
        step(4);
        btn_fire = 1'b0;
        step(1);
        chk("to_mode", 32'(fire_mode), 32'd3);
        chk("to_tgt", 32'(target_cnt), 32'd5);
        step(8);
        chk("to_trig8_high", 32'(trigger), 32'd1);
        step(1);
        chk("to_rel_trig", 32'(trigger), 32'd0);
        chk("to_fail_pulse", 32'(shot_fail), 32'd1);
        chk("to_no_ok", 32'(shot_ok), 32'd0);
        step(3);
        chk("to_idle", 32'(busy), 32'd0);
        chk("to_trig_cycles", 32'(n_trig_cyc - b_trig_cyc), 32'd8);
        chk("to_fail_cnt", 32'(n_fail - b_fail), 32'd1);
        chk("to_count_kept", 32'(shot_count), 32'(CNT_EN * 1));

        // Rapid burst, shoot answers every TRIG; inputs change mid-burst
        snap();
        mode_in    = 3'b100;
        targets_in = 5'd7;
        shoot      = 1'b1;
        btn_fire   = 1'b1;
        step(4);
        btn_fire = 1'b0;
        step(1);
        mode_in    = 3'b001;
        targets_in = 5'd2;
        step(20);
        shoot = 1'b0;
        chk("rb_rises", 32'(n_rise - b_rise), 32'd3);
        chk("rb_ok", 32'(n_ok - b_ok), 32'd3);
        chk("rb_fail", 32'(n_fail - b_fail), 32'd0);
        chk("rb_trig_cycles", 32'(n_trig_cyc - b_trig_cyc), 32'd3);
        chk("rb_idle", 32'(busy), 32'd0);
        chk("rb_mode_held", 32'(fire_mode), 32'd4);
        chk("rb_tgt_held", 32'(target_cnt), 32'd7);
        chk("rb_count", 32'(shot_count), 32'(CNT_EN * 4));

        // Rapid burst failing on the 2nd shot, refill pressed mid-burst
        snap();
        mode_in  = 3'b100;
        shoot    = 1'b1;
        btn_fire = 1'b1;
        step(4);
        btn_fire = 1'b0;
        step(2);
        chk("rf_trig1", 32'(trigger), 32'd1);
        step(1);
        chk("rf_ok1", 32'(shot_ok), 32'd1);
        shoot      = 1'b0;
        btn_refill = 1'b1;
        step(20);
        chk("rf_rises", 32'(n_rise - b_rise), 32'd2);
        chk("rf_ok", 32'(n_ok - b_ok), 32'd1);
        chk("rf_fail", 32'(n_fail - b_fail), 32'd1);
        chk("rf_idle", 32'(busy), 32'd0);
        btn_refill = 1'b0;
        step(8);
        chk("rf_refill_ignored", 32'(n_refill_cyc - b_refill_cyc), 32'd0);

        // Simultaneous fire and refill edges: fire wins
        snap();
        mode_in    = 3'b000;
        shoot      = 1'b1;
        btn_fire   = 1'b1;
        btn_refill = 1'b1;
        step(4);
        step(1);
        chk("sim_arm_busy", 32'(busy), 32'd1);
        chk("sim_no_refill", 32'(refill), 32'd0);
        btn_fire   = 1'b0;
        btn_refill = 1'b0;
        step(6);
        shoot = 1'b0;
        chk("sim_idle", 32'(busy), 32'd0);
        chk("sim_ok", 32'(n_ok - b_ok), 32'd1);
        chk("sim_refill_cycles", 32'(n_refill_cyc - b_refill_cyc), 32'd0);
        step(6);

        // Refill alone
        snap();
        btn_refill = 1'b1;
        step(4);
        btn_refill = 1'b0;
        step(1);
        chk("rfl_first", 32'(refill), 32'd1);
        chk("rfl_busy", 32'(busy), 32'd1);
        step(3);
        chk("rfl_fourth", 32'(refill), 32'd1);
        step(1);
        chk("rfl_gap", 32'(refill), 32'd0);
        step(2);
        chk("rfl_gap3_busy", 32'(busy), 32'd1);
        step(1);
        chk("rfl_idle", 32'(busy), 32'd0);
        chk("rfl_cycles", 32'(n_refill_cyc - b_refill_cyc), 32'd4);
        chk("rfl_no_trig", 32'(n_trig_cyc - b_trig_cyc), 32'd0);
        chk("count_before_reset", 32'(shot_count), 32'(CNT_EN * 6));

        // Reset during 2nd TRIG cycle, fire held through reset release
        mode_in  = 3'b010;
        btn_fire = 1'b1;
        step(4);
        step(2);
        step(1);
        chk("mr_trig2", 32'(trigger), 32'd1);
        reset = 1'b1;
        step(1);
        chk("mr_trig", 32'(trigger), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_count", 32'(shot_count), 32'd0);
        chk("mr_mode", 32'(fire_mode), 32'd0);
        reset = 1'b0;
        snap();
        step(15);
        chk("mr_held_no_trig", 32'(n_rise - b_rise), 32'd0);
        chk("mr_held_idle", 32'(busy), 32'd0);
        btn_fire = 1'b0;
        step(6);
        btn_fire = 1'b1;
        step(4);
        btn_fire = 1'b0;
        step(2);
        chk("mr_repress_trig", 32'(trigger), 32'd1);
        chk("mr_repress_mode", 32'(fire_mode), 32'd2);
        shoot = 1'b1;
        step(1);
        shoot = 1'b0;
        step(3);
        chk("mr_final_idle", 32'(busy), 32'd0);
        chk("mr_final_count", 32'(shot_count), 32'(CNT_EN * 1));

        // Invariants over the whole run
        chk("inv_trig_refill", 32'(n_overlap), 32'd0);
        chk("inv_ok_fail", 32'(n_both_pulse), 32'd0);
        chk("inv_gap_ge4", 32'(n_short_gap), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
